// File: rtl/led_bank_arbiter.sv
// Round-robin owner arbitration for the shared 5-LED bank with a minimum dwell per owner.
// Optional idle heartbeat on LED5 is enabled by defining LED_ARB_HEARTBEAT_EN.
module led_bank_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int HOLD_CYCLES = 12000000,
   parameter int BLINK_DIV   = 3000000
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [5*NUM_REQ-1:0]   pattern,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [4:0]             leds,
   output logic                   busy,
   output logic                   dbg_state_o
);

   localparam int            IW       = $clog2(NUM_REQ);
   localparam int            CW       = $clog2(HOLD_CYCLES + 1);
   localparam logic [IW:0]   N_W      = (IW + 1)'(NUM_REQ);
   localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_CYCLES < 1 || BLINK_DIV < 1) begin : g_param_err
      $error("led_bank_arbiter: illegal parameter value");
   end

   typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [4:0]          leds_q, leds_d;
   logic                busy_q, busy_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [4:0]          pat [NUM_REQ];
   logic [NUM_REQ-1:0]  cand;
   logic [IW-1:0]       win;
   logic                take;
   logic [4:0]          idle_leds;

   // First set bit of m at or above p, wrapping past NUM_REQ-1 back to 0.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] m,
                                             input logic [IW-1:0]      p);
      logic [IW:0] idx;
      logic        found;
      rr_pick = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, p} + k[IW:0];
         if (idx >= N_W) idx = idx - N_W;
         if (!found && m[idx[IW-1:0]]) begin
            rr_pick = idx[IW-1:0];
            found   = 1'b1;
         end
      end
   endfunction

   function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
      inc_wrap = ({1'b0, i} == N_W - 1'b1) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) pat[i] = pattern[5*i +: 5];
   end

`ifdef LED_ARB_HEARTBEAT_EN
   localparam int            DW       = $clog2(BLINK_DIV + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          hb_q, hb_d;

   // Free-running divider; it keeps counting while the bank is owned.
   always_comb begin
      div_d = div_q + 1'b1;
      hb_d  = hb_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         hb_d  = ~hb_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         div_q <= '0;
         hb_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         hb_q  <= hb_d;
      end
   end

   assign idle_leds = {hb_d, 4'b0000};
`else
   assign idle_leds = 5'b00000;
`endif

   // The current owner is excluded so an expired dwell hands over to someone else first.
   always_comb begin
      cand = req;
      if (state_q == S_OWN) cand[owner_q] = 1'b0;
      win  = rr_pick(cand, ptr_q);
      take = (|cand) && ((state_q == S_IDLE) || (cnt_q == '0));
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      leds_d  = (state_q == S_OWN) ? pat[owner_q] : idle_leds;

      if (take) begin
         state_d    = S_OWN;
         gnt_d      = '0;
         gnt_d[win] = 1'b1;
         busy_d     = 1'b1;
         cnt_d      = CNT_LOAD;
         ptr_d      = inc_wrap(win);
         owner_d    = win;
         leds_d     = pat[win];
      end else if (state_q == S_OWN) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else if (!req[owner_q]) begin
            state_d = S_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            leds_d  = idle_leds;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         leds_q  <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         leds_q  <= leds_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt         = gnt_q;
   assign leds        = leds_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed vector table plus randomized traffic against a dwell-age model.
module tb_led_bank_arbiter;

   localparam int N  = 3;
   localparam int H  = 4;
   localparam int N2 = 2;
   localparam int H2 = 1;
   localparam int B  = 5;
`ifdef LED_ARB_HEARTBEAT_EN
   localparam bit HB_EN = 1'b1;
`else
   localparam bit HB_EN = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic [N-1:0]    req = '0;
   logic [5*N-1:0]  pattern = '0;
   logic [N-1:0]    gnt;
   logic [4:0]      leds;
   logic            busy, dbg;
   logic [N2-1:0]   req2 = '0;
   logic [5*N2-1:0] pattern2 = '0;
   logic [N2-1:0]   gnt2;
   logic [4:0]      leds2;
   logic            busy2, dbg2;

   int n_checks = 0;
   int n_fail   = 0;
   logic [8:0] exp_q[$];

   // clock / reset: RST_N is driven per cycle by the stimulus below
   always #5 CLK = ~CLK;

   led_bank_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H), .BLINK_DIV(B)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .req(req), .pattern(pattern),
      .gnt(gnt), .leds(leds), .busy(busy), .dbg_state_o(dbg));

   led_bank_arbiter #(.NUM_REQ(N2), .HOLD_CYCLES(H2), .BLINK_DIV(B)) u_fast (
      .CLK(CLK), .RST_N(RST_N), .req(req2), .pattern(pattern2),
      .gnt(gnt2), .leds(leds2), .busy(busy2), .dbg_state_o(dbg2));

   // Reference: an owner of age >= hold may be displaced by any other requester
   // (round-robin from ptr); otherwise it keeps the bank while it still asks.
   typedef struct {
      bit         owned;
      int         owner;
      int         ptr;
      int         age;
      int         k;
      logic [7:0] gnt;
      logic [4:0] leds;
      bit         busy;
   } mdl_t;

   mdl_t m1, m2;

   function automatic mdl_t mstep(mdl_t m, int n, int hold, logic [7:0] rq,
                                  logic [39:0] pt, logic rn);
      mdl_t r = m;
      logic [7:0] c;
      int w;
      if (!rn) begin
         r.owned = 0; r.owner = 0; r.ptr = 0; r.age = 0; r.k = 0;
      end else begin
         r.k = m.k + 1;
         if (m.owned && m.age < hold) begin
            r.age = m.age + 1;
         end else begin
            c = rq;
            if (m.owned) c[m.owner] = 1'b0;
            w = -1;
            for (int s = 0; s < n; s++)
               if (w < 0 && c[(m.ptr + s) % n]) w = (m.ptr + s) % n;
            if (w >= 0) begin
               r.owned = 1; r.owner = w; r.age = 1; r.ptr = (w + 1) % n;
            end else if (m.owned && rq[m.owner]) begin
               r.age = m.age + 1;
            end else begin
               r.owned = 0;
            end
         end
      end
      r.gnt = '0;
      if (r.owned) r.gnt[r.owner] = 1'b1;
      r.busy = r.owned;
      r.leds = 5'b00000;
      if (rn && r.owned) r.leds = pt[5*r.owner +: 5];
      else if (rn && HB_EN && ((r.k / B) % 2 == 1)) r.leds = 5'b10000;
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: apply one cycle of stimulus, clock it, score both instances
   task automatic run_cycle(input logic rn, input logic [N-1:0] rq, input logic [5*N-1:0] pt,
                            input bit from_tbl, input logic [8:0] tbl_exp);
      logic [8:0] e;
      RST_N    = rn;
      req      = rq;
      pattern  = pt;
      req2     = N2'($urandom_range(0, 3));
      pattern2 = 10'($urandom);
      m1 = mstep(m1, N, H, 8'(rq), 40'(pt), rn);
      m2 = mstep(m2, N2, H2, 8'(req2), 40'(pattern2), rn);
      exp_q.push_back(from_tbl ? tbl_exp : {m1.gnt[2:0], m1.leds, m1.busy});
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      check("gnt",  8'(gnt),  8'(e[8:6]));
      check("busy", 8'(busy), 8'(e[0]));
      check("dbg",  8'(dbg),  8'(e[0]));
      if (e[0] || !HB_EN || !from_tbl) check("leds", 8'(leds), 8'(e[5:1]));
      check("fast_gnt",  8'(gnt2),  m2.gnt);
      check("fast_leds", 8'(leds2), 8'(m2.leds));
      check("fast_busy", 8'(busy2), 8'(m2.busy));
   endtask

   typedef struct {
      logic        rn;
      logic [2:0]  rq;
      logic [14:0] pat;
      logic [2:0]  eg;
      logic [4:0]  el;
      logic        eb;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rn, input logic [2:0] rq, input logic [14:0] pat,
                      input logic [2:0] eg, input logic [4:0] el, input logic eb);
      vec_t v;
      v.rn = rn; v.rq = rq; v.pat = pat; v.eg = eg; v.el = el; v.eb = eb;
      tbl.push_back(v);
   endtask

   initial begin
      logic [14:0] pa, pb;
      logic [2:0]  rq;
      pa = {5'b10101, 5'b00111, 5'b11110};
      pb = {5'b10101, 5'b11000, 5'b11110};
      m1 = '{default: 0};
      m2 = '{default: 0};

      // reset held with both requesting, then contention/fairness
      repeat (3) add(1'b0, 3'b011, pa, 3'b000, 5'b00000, 1'b0);
      repeat (4) add(1'b1, 3'b011, pa, 3'b001, 5'b11110, 1'b1);
      repeat (4) add(1'b1, 3'b011, pa, 3'b010, 5'b00111, 1'b1);
      add(1'b1, 3'b011, pa, 3'b001, 5'b11110, 1'b1);
      // reset mid-grant, then pointer back at 0
      add(1'b1, 3'b011, pa, 3'b001, 5'b11110, 1'b1);
      add(1'b0, 3'b011, pa, 3'b000, 5'b00000, 1'b0);
      add(1'b1, 3'b011, pa, 3'b001, 5'b11110, 1'b1);
      // single request dropped early: full dwell then idle
      add(1'b0, 3'b000, pa, 3'b000, 5'b00000, 1'b0);
      add(1'b1, 3'b010, pa, 3'b010, 5'b00111, 1'b1);
      repeat (3) add(1'b1, 3'b000, pa, 3'b010, 5'b00111, 1'b1);
      repeat (2) add(1'b1, 3'b000, pa, 3'b000, 5'b00000, 1'b0);
      // grant index 2, pointer wraps to 0
      add(1'b1, 3'b100, pa, 3'b100, 5'b10101, 1'b1);
      repeat (3) add(1'b1, 3'b101, pa, 3'b100, 5'b10101, 1'b1);
      add(1'b1, 3'b101, pa, 3'b001, 5'b11110, 1'b1);
      // sole requester keeps bank past dwell, then yields at once
      repeat (5) add(1'b1, 3'b001, pa, 3'b001, 5'b11110, 1'b1);
      add(1'b1, 3'b011, pa, 3'b010, 5'b00111, 1'b1);
      // owner pattern change is tracked
      add(1'b1, 3'b010, pb, 3'b010, 5'b11000, 1'b1);

      foreach (tbl[i])
         run_cycle(tbl[i].rn, tbl[i].rq, tbl[i].pat, 1'b1, {tbl[i].eg, tbl[i].el, tbl[i].eb});

      // randomized traffic with sticky requests and occasional reset
      rq = 3'b000;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
         run_cycle(($urandom_range(0, 79) != 0), rq, 15'($urandom), 1'b0, 9'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
